// File: rtl/uart_alu_cmd_seq.sv
// Command sequencer between UART RX/TX FIFOs and a combinational ALU with multi-byte operands.
// Optional trailing frame check byte is enabled by defining CMD_CHECKSUM_EN.
module uart_alu_cmd_seq #(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned OP_BYTES    = 2,
  parameter int unsigned OPCODE_BITS = 6,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_rx_empty,
  input  logic [DATA_BITS-1:0]          i_r_data,
  output logic                          o_rd_uart,
  input  logic                          i_tx_full,
  output logic [DATA_BITS-1:0]          o_w_data,
  output logic                          o_wr_uart,
  output logic [OP_BYTES*DATA_BITS-1:0] o_op_a,
  output logic [OP_BYTES*DATA_BITS-1:0] o_op_b,
  output logic [OPCODE_BITS-1:0]        o_op_code,
  input  logic [OP_BYTES*DATA_BITS-1:0] i_alu_result,
  output logic                          o_busy,
  output logic                          o_err,
  output logic [7:0]                    o_cmd_count
);

  localparam int unsigned W  = OP_BYTES * DATA_BITS;
  localparam int unsigned CW = (OP_BYTES > 1) ? $clog2(OP_BYTES) : 1;
  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(OP_BYTES - 1);
  localparam logic [TW-1:0] TMO_LAST = (TIMEOUT_CYC > 0) ? TW'(TIMEOUT_CYC - 1) : '0;

  typedef enum logic [2:0] {
    StRdA,
    StRdB,
    StRdOp,
    StExec,
    StTx
`ifdef CMD_CHECKSUM_EN
    ,
    StRdChk,
    StErrTx
`endif
  } state_e;

  state_e               r_state;
  logic [CW-1:0]        r_cnt;
  logic [TW-1:0]        r_tmo;
  logic [W-1:0]         r_a_sh;
  logic [W-1:0]         r_b_sh;
  logic [W-1:0]         r_shift;
  logic [W-1:0]         r_op_a;
  logic [W-1:0]         r_op_b;
  logic [OPCODE_BITS-1:0] r_op_code;
  logic                 r_err;
  logic [7:0]           r_cmd_count;
`ifdef CMD_CHECKSUM_EN
  logic [OPCODE_BITS-1:0] r_opc_sh;
  logic [DATA_BITS-1:0]   r_chk;
`endif

  logic w_rd_state;
  logic w_tx_state;
  logic w_busy;
  logic w_pop;
  logic w_push;
  logic w_tmo;

  always_comb begin
    w_rd_state = (r_state == StRdA) || (r_state == StRdB) || (r_state == StRdOp);
    w_tx_state = (r_state == StTx);
`ifdef CMD_CHECKSUM_EN
    w_rd_state = w_rd_state || (r_state == StRdChk);
    w_tx_state = w_tx_state || (r_state == StErrTx);
`endif
  end

  // Pop/push are gated by reset so nothing moves while the block is held in reset.
  assign w_busy = (r_state != StRdA) || (r_cnt != '0);
  assign w_pop  = i_reset && w_rd_state && !i_rx_empty;
  assign w_push = i_reset && w_tx_state && !i_tx_full;
  assign w_tmo  = (TIMEOUT_CYC != 0) && w_rd_state && w_busy && !w_pop && (r_tmo == TMO_LAST);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= StRdA;
      r_cnt       <= '0;
      r_tmo       <= '0;
      r_a_sh      <= '0;
      r_b_sh      <= '0;
      r_shift     <= '0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_op_code   <= '0;
      r_err       <= 1'b0;
      r_cmd_count <= '0;
`ifdef CMD_CHECKSUM_EN
      r_opc_sh    <= '0;
      r_chk       <= '0;
`endif
    end else begin
      r_err <= 1'b0;

      if (TIMEOUT_CYC == 0 || !w_rd_state || !w_busy || w_pop || w_tmo) begin
        r_tmo <= '0;
      end else begin
        r_tmo <= r_tmo + TW'(1);
      end

      unique case (r_state)
        StRdA: begin
          if (w_pop) begin
            r_a_sh[int'(r_cnt)*DATA_BITS +: DATA_BITS] <= i_r_data;
`ifdef CMD_CHECKSUM_EN
            r_chk <= (r_cnt == '0) ? i_r_data : (r_chk ^ i_r_data);
`endif
            if (r_cnt == CNT_LAST) begin
              r_cnt   <= '0;
              r_state <= StRdB;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end

        StRdB: begin
          if (w_pop) begin
            r_b_sh[int'(r_cnt)*DATA_BITS +: DATA_BITS] <= i_r_data;
`ifdef CMD_CHECKSUM_EN
            r_chk <= r_chk ^ i_r_data;
`endif
            if (r_cnt == CNT_LAST) begin
              r_cnt   <= '0;
              r_state <= StRdOp;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end

        StRdOp: begin
          if (w_pop) begin
`ifdef CMD_CHECKSUM_EN
            r_opc_sh <= i_r_data[OPCODE_BITS-1:0];
            r_chk    <= r_chk ^ i_r_data;
            r_state  <= StRdChk;
`else
            r_op_a    <= r_a_sh;
            r_op_b    <= r_b_sh;
            r_op_code <= i_r_data[OPCODE_BITS-1:0];
            r_state   <= StExec;
`endif
          end
        end

`ifdef CMD_CHECKSUM_EN
        StRdChk: begin
          if (w_pop) begin
            if (i_r_data == r_chk) begin
              r_op_a    <= r_a_sh;
              r_op_b    <= r_b_sh;
              r_op_code <= r_opc_sh;
              r_state   <= StExec;
            end else begin
              // Rejected frame answers with a single 0xEE byte through the TX path.
              r_err   <= 1'b1;
              r_shift <= W'(8'hEE);
              r_state <= StErrTx;
            end
          end
        end

        StErrTx: begin
          if (w_push) begin
            r_state <= StRdA;
          end
        end
`endif

        StExec: begin
          r_shift <= i_alu_result;
          r_cnt   <= '0;
          r_state <= StTx;
        end

        StTx: begin
          if (w_push) begin
            r_shift <= r_shift >> DATA_BITS;
            if (r_cnt == CNT_LAST) begin
              r_cnt       <= '0;
              r_cmd_count <= r_cmd_count + 8'd1;
              r_state     <= StRdA;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end

        default: r_state <= StRdA;
      endcase

      // A pop in the expiry cycle keeps w_tmo low, so an accepted byte always wins.
      if (w_tmo) begin
        r_state <= StRdA;
        r_cnt   <= '0;
        r_err   <= 1'b1;
      end
    end
  end

  assign o_rd_uart   = w_pop;
  assign o_wr_uart   = w_push;
  assign o_w_data    = r_shift[DATA_BITS-1:0];
  assign o_op_a      = r_op_a;
  assign o_op_b      = r_op_b;
  assign o_op_code   = r_op_code;
  assign o_busy      = w_busy;
  assign o_err       = r_err;
  assign o_cmd_count = r_cmd_count;

endmodule
